// File: rtl/cursor_gain_scaler_if.sv
// Handshake bundle between the cursor-delta source, the gain scaler and the HID report packer.
// The gain scaler itself connects through the slave modport.
interface cursor_gain_scaler_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_dx;
    logic signed [7:0] in_dy;
    logic signed [15:0] gain_in;
    logic              resid_clr;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_dx;
    logic signed [7:0] out_dy;
    logic              sat_x;
    logic              sat_y;

    modport master (
        output in_valid, in_dx, in_dy, gain_in, resid_clr, out_ready,
        input  in_ready, out_valid, out_dx, out_dy, sat_x, sat_y
    );

    modport slave (
        input  in_valid, in_dx, in_dy, gain_in, resid_clr, out_ready,
        output in_ready, out_valid, out_dx, out_dy, sat_x, sat_y
    );
endinterface

// File: rtl/cursor_gain_scaler.sv
// Scales raw cursor deltas by a clamped Q8.8 gain, carries the sub-pixel residue between
// reports and saturates the result to a symmetric signed 8-bit range.
module cursor_gain_scaler #(
    parameter logic signed [15:0] GAIN_MIN  = 16'sd64,
    parameter logic signed [15:0] GAIN_MAX  = 16'sd1024,
    parameter int                 OUT_LIMIT = 127
) (
    input logic                 clk,
    input logic                 rst,
    cursor_gain_scaler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

    typedef struct packed {
        logic [7:0] val;
        logic       sat;
        logic [7:0] resid;
    } axis_t;

    state_e             state_q, state_d;
    logic signed [7:0]  dx_q, dx_d, dy_q, dy_d;
    logic signed [15:0] gain_q, gain_d;
    logic [7:0]         resid_x_q, resid_x_d, resid_y_q, resid_y_d;
    logic [7:0]         out_dx_q, out_dx_d, out_dy_q, out_dy_d;
    logic               sat_x_q, sat_x_d, sat_y_q, sat_y_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready;
    axis_t              ax, ay;

    function automatic axis_t scale_axis(input logic signed [7:0] d,
                                         input logic signed [15:0] g,
                                         input logic [7:0] resid);
        logic signed [23:0] dext, gext, sum, q, lim, neg_lim;
        axis_t              r;
        dext    = {{16{d[7]}}, d};
        gext    = {{8{g[15]}}, g};
        sum     = dext * gext + $signed({16'b0, resid});
        q       = sum >>> 8;
        lim     = 24'(OUT_LIMIT);
        neg_lim = -lim;
        r.val   = q[7:0];
        r.sat   = 1'b0;
        r.resid = sum[7:0];
        // An idle axis drops its residue so a stale fraction cannot creep the cursor.
        if (d == 8'sd0) begin
            r.val   = 8'd0;
            r.resid = 8'd0;
        end else if (q > lim) begin
            r.val   = lim[7:0];
            r.sat   = 1'b1;
            r.resid = 8'd0;
        end else if (q < neg_lim) begin
            r.val   = neg_lim[7:0];
            r.sat   = 1'b1;
            r.resid = 8'd0;
        end
        return r;
    endfunction

    assign in_ready      = (state_q == StIdle) && !rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dx    = out_dx_q;
    assign bus.out_dy    = out_dy_q;
    assign bus.sat_x     = sat_x_q;
    assign bus.sat_y     = sat_y_q;

    assign ax = scale_axis(dx_q, gain_q, resid_x_q);
    assign ay = scale_axis(dy_q, gain_q, resid_y_q);

    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        gain_d      = gain_q;
        resid_x_d   = resid_x_q;
        resid_y_d   = resid_y_q;
        out_dx_d    = out_dx_q;
        out_dy_d    = out_dy_q;
        sat_x_d     = sat_x_q;
        sat_y_d     = sat_y_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready) begin
                    dx_d    = bus.in_dx;
                    dy_d    = bus.in_dy;
                    gain_d  = (bus.gain_in < GAIN_MIN) ? GAIN_MIN :
                              (bus.gain_in > GAIN_MAX) ? GAIN_MAX : bus.gain_in;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                out_dx_d    = ax.val;
                out_dy_d    = ay.val;
                sat_x_d     = ax.sat;
                sat_y_d     = ay.sat;
                resid_x_d   = ax.resid;
                resid_y_d   = ay.resid;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.resid_clr) begin
            resid_x_d = 8'd0;
            resid_y_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dx_q        <= '0;
            dy_q        <= '0;
            gain_q      <= '0;
            resid_x_q   <= '0;
            resid_y_q   <= '0;
            out_dx_q    <= '0;
            out_dy_q    <= '0;
            sat_x_q     <= 1'b0;
            sat_y_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            gain_q      <= gain_d;
            resid_x_q   <= resid_x_d;
            resid_y_q   <= resid_y_d;
            out_dx_q    <= out_dx_d;
            out_dy_q    <= out_dy_d;
            sat_x_q     <= sat_x_d;
            sat_y_q     <= sat_y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cursor_gain_scaler.sv
// Scoreboard bench for cursor_gain_scaler: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of gain, floor, residue and saturation.
module tb_cursor_gain_scaler;

    typedef struct {
        int dx;
        int dy;
        int sx;
        int sy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cursor_gain_scaler_if bus ();

    cursor_gain_scaler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_sent = 0;
    int   n_out = 0;
    int   rx = 0;
    int   ry = 0;
    int   last_dx = 0;
    int   last_dy = 0;
    int   last_sx = 0;
    int   last_sy = 0;
    bit   rand_ready = 1'b0;
    bit   hold_pending = 1'b0;
    int   held_dx, held_dy, held_sx, held_sy;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: clamp gain, multiply, floor-divide by 256, saturate.
    function automatic void ref_axis(input int d, input int graw, input int r,
                                     output int o, output int s, output int rn);
        int g, sum, q;
        g   = (graw < 64) ? 64 : (graw > 1024) ? 1024 : graw;
        sum = d * g + r;
        q   = (sum >= 0) ? sum / 256 : -((-sum + 255) / 256);
        if (d == 0) begin
            o = 0; s = 0; rn = 0;
        end else if (q > 127) begin
            o = 127; s = 1; rn = 0;
        end else if (q < -127) begin
            o = -127; s = 1; rn = 0;
        end else begin
            o = q; s = 0; rn = sum - q * 256;
        end
    endfunction

    task automatic send(input int dx, input int dy, input int g);
        int   budget = 0;
        int   nrx, nry;
        exp_t e;
        logic [31:0] vx, vy, vg;
        vx = dx; vy = dy; vg = g;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_dx    = vx[7:0];
        bus.in_dy    = vy[7:0];
        bus.gain_in  = vg[15:0];
        while (!bus.in_ready && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        ref_axis(dx, g, rx, e.dx, e.sx, nrx);
        ref_axis(dy, g, ry, e.dy, e.sy, nry);
        rx = nrx;
        ry = nry;
        exp_q.push_back(e);
        n_sent++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 bus.resid_clr = 1'b1;
        @(posedge clk); #1 bus.resid_clr = 1'b0;
        rx = 0;
        ry = 0;
    endtask

    task automatic wait_out(input int target);
        int budget = 0;
        while (n_out < target && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (n_out < target) check("output_timeout", n_out, target);
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stability under backpressure.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (hold_pending) begin
                check("hold_dx", int'(bus.out_dx), held_dx);
                check("hold_dy", int'(bus.out_dy), held_dy);
                check("hold_sat", int'({bus.sat_x, bus.sat_y}), held_sx * 2 + held_sy);
            end
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_dx", int'(bus.out_dx), e.dx);
                    check("out_dy", int'(bus.out_dy), e.dy);
                    check("sat_x", int'(bus.sat_x), e.sx);
                    check("sat_y", int'(bus.sat_y), e.sy);
                end
                last_dx = int'(bus.out_dx);
                last_dy = int'(bus.out_dy);
                last_sx = int'(bus.sat_x);
                last_sy = int'(bus.sat_y);
                n_out++;
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                held_dx = int'(bus.out_dx);
                held_dy = int'(bus.out_dy);
                held_sx = int'(bus.sat_x);
                held_sy = int'(bus.sat_y);
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_dx     = 8'sd3;
        bus.in_dy     = 8'sd3;
        bus.gain_in   = 16'sd256;
        bus.resid_clr = 1'b0;
        bus.out_ready = 1'b1;

        // Reset held three cycles with in_valid high.
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", int'(bus.in_ready), 0);
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_dx", int'(bus.out_dx), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release_in_ready", int'(bus.in_ready), 1);

        // Unity gain, with latency check.
        send(5, -3, 256);
        @(negedge clk);
        check("latency_calc", int'(bus.out_valid), 0);
        @(negedge clk);
        check("latency_out", int'(bus.out_valid), 1);
        wait_out(1);
        check("unity_dx", last_dx, 5);
        check("unity_dy", last_dy, -3);

        // 1.5x gain: residue carry in both directions.
        clr_pulse();
        send(1, 0, 384); wait_out(2); check("frac_p1", last_dx, 1);
        send(1, 0, 384); wait_out(3); check("frac_p2", last_dx, 2);
        clr_pulse();
        send(-1, 0, 384); wait_out(4); check("frac_n1", last_dx, -2);
        send(-1, 0, 384); wait_out(5); check("frac_n2", last_dx, -1);
        check("frac_dy0", last_dy, 0);

        // Saturation zeroes the residue.
        send(100, -100, 1024); wait_out(6);
        check("sat_dx", last_dx, 127);
        check("sat_dy", last_dy, -127);
        check("sat_flags", last_sx + last_sy, 2);
        send(1, 0, 1024); wait_out(7); check("post_sat_dx", last_dx, 4);

        // Backpressure: second pair waits while output is held.
        bus.out_ready = 1'b0;
        send(7, 7, 256);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_dx    = 8'sd9;
        bus.in_dy    = 8'sd9;
        bus.gain_in  = 16'sd256;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_dx", int'(bus.out_dx), 7);
        end
        bus.out_ready = 1'b1;
        send(9, 9, 256);
        wait_out(9);
        check("bp_second_dx", last_dx, 9);

        // Gain clamps and residue clear during CALC.
        clr_pulse();
        send(4, 0, -50); wait_out(10); check("clamp_low", last_dx, 1);
        send(10, 0, 2000); wait_out(11); check("clamp_high", last_dx, 40);
        send(1, 0, 384);
        bus.resid_clr = 1'b1;
        @(posedge clk); #1 bus.resid_clr = 1'b0;
        rx = 0;
        ry = 0;
        wait_out(12);
        send(1, 0, 384); wait_out(13); check("clr_in_calc", last_dx, 1);

        // Randomized traffic with random backpressure and occasional residue clears.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int dx, dy, g;
            dx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            dy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) == 0) begin
                dx = int'($urandom_range(0, 6)) - 3;
                dy = int'($urandom_range(0, 6)) - 3;
            end
            g = int'($urandom_range(0, 2399)) - 200;
            if ($urandom_range(0, 15) == 0) clr_pulse();
            send(dx, dy, g);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_out(n_sent);
        check("all_drained", n_out, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
